// File: rtl/garegga_pkg.sv
// rtl/garegga_pkg.sv - shared opcodes and FSM states for the 93C46-style serial EEPROM
package garegga_pkg;

  localparam int WORD_W = 16;

  localparam logic [1:0] OP_EXT   = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_READ  = 2'b10;
  localparam logic [1:0] OP_ERASE = 2'b11;

  // Extended opcodes live in the top two address bits when the opcode is OP_EXT
  localparam logic [1:0] EXT_EWDS = 2'b00;
  localparam logic [1:0] EXT_WRAL = 2'b01;
  localparam logic [1:0] EXT_ERAL = 2'b10;
  localparam logic [1:0] EXT_EWEN = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    READ,
    WDATA,
    BUSY,
    WAITCS
  } state_t;

endpackage

// File: rtl/garegga_eeprom_ram.sv
// rtl/garegga_eeprom_ram.sv - 64x16 dual-port word store, port A serial side, port B host side
module garegga_eeprom_ram
  import garegga_pkg::*;
#(
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic [ADDR_W-1:0] addr_a,
  input  logic [WORD_W-1:0] din_a,
  input  logic              we_a,
  output logic [WORD_W-1:0] dout_a,
  input  logic [ADDR_W-1:0] addr_b,
  input  logic [WORD_W-1:0] din_b,
  input  logic              we_b,
  output logic [WORD_W-1:0] dout_b
);

  logic [WORD_W-1:0] mem [1 << ADDR_W];

  // Port A is written last so a serial commit overrides a same-cycle host load
  always_ff @(posedge clk) begin
    if (we_b) mem[addr_b] <= din_b;
    if (we_a) mem[addr_a] <= din_a;
  end

  assign dout_a = mem[addr_a];
  assign dout_b = mem[addr_b];

endmodule

// File: rtl/garegga_eeprom.sv
// rtl/garegga_eeprom.sv - 93C46 x16 serial EEPROM emulation with host NVRAM load/save port
module garegga_eeprom
  import garegga_pkg::*;
#(
  parameter int ADDR_W      = 6,
  parameter int BUSY_CYCLES = 4800
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic              EEPROM_SCS,
  input  logic              EEPROM_SCLK,
  input  logic              EEPROM_SDI,
  output logic              EEPROM_SDO,
  input  logic [ADDR_W-1:0] HOST_ADDR,
  input  logic [15:0]       HOST_DIN,
  input  logic              HOST_WE,
  output logic [15:0]       HOST_DOUT,
  output logic              DIRTY,
  input  logic              HOST_DIRTY_CLR
);

  localparam int CMD_W = ADDR_W + 2;
  localparam int BW    = $clog2(BUSY_CYCLES + (1 << ADDR_W) + 1);
  localparam logic [BW-1:0] DEPTH_C   = BW'(1 << ADDR_W);
  localparam logic [BW-1:0] LAST_BUSY = BW'(BUSY_CYCLES - 1);
  localparam logic [4:0]    LAST_CMD  = 5'(CMD_W - 1);

  logic [1:0] scs_sync, sclk_sync, sdi_sync;
  logic       sclk_prev;
  logic       scs, sdi, sclk_rise;

  state_t            state, state_n;
  logic [CMD_W-2:0]  cmd, cmd_n;
  logic [CMD_W-1:0]  shifted;
  logic [4:0]        bit_cnt, bit_cnt_n;
  logic [ADDR_W-1:0] addr, addr_n;
  logic [15:0]       data, data_n;
  logic              all_op, all_n;
  logic              pending, pend_n;
  logic              wen, wen_n;
  logic              sdo, sdo_n;
  logic [BW-1:0]     busy_cnt, busy_n;
  logic              dirty, host_dirty_n;
  logic [15:0]       host_dout;

  logic [ADDR_W-1:0] addr_a;
  logic              we_a;
  logic [15:0]       ram_a_q, ram_b_q;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      scs_sync  <= '0;
      sclk_sync <= '0;
      sdi_sync  <= '0;
      sclk_prev <= 1'b0;
    end else begin
      scs_sync  <= {scs_sync[0], EEPROM_SCS};
      sclk_sync <= {sclk_sync[0], EEPROM_SCLK};
      sdi_sync  <= {sdi_sync[0], EEPROM_SDI};
      sclk_prev <= sclk_sync[1];
    end
  end

  assign scs       = scs_sync[1];
  assign sdi       = sdi_sync[1];
  assign sclk_rise = sclk_sync[1] & ~sclk_prev;
  assign shifted   = {cmd, sdi};

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state     <= IDLE;
      cmd       <= '0;
      bit_cnt   <= '0;
      addr      <= '0;
      data      <= '0;
      all_op    <= 1'b0;
      pending   <= 1'b0;
      wen       <= 1'b0;
      sdo       <= 1'b1;
      busy_cnt  <= '0;
      dirty     <= 1'b0;
      host_dout <= '0;
    end else begin
      state     <= state_n;
      cmd       <= cmd_n;
      bit_cnt   <= bit_cnt_n;
      addr      <= addr_n;
      data      <= data_n;
      all_op    <= all_n;
      pending   <= pend_n;
      wen       <= wen_n;
      sdo       <= sdo_n;
      busy_cnt  <= busy_n;
      dirty     <= host_dirty_n;
      host_dout <= ram_b_q;
    end
  end

  always_comb begin
    state_n   = state;
    cmd_n     = cmd;
    bit_cnt_n = bit_cnt;
    addr_n    = addr;
    data_n    = data;
    all_n     = all_op;
    pend_n    = pending;
    wen_n     = wen;
    sdo_n     = sdo;
    busy_n    = busy_cnt;
    unique case (state)
      IDLE: begin
        sdo_n = 1'b1;
        if (scs && sclk_rise && sdi) begin
          state_n   = CMD;
          cmd_n     = '0;
          bit_cnt_n = '0;
        end
      end
      CMD: begin
        if (!scs) begin
          state_n = IDLE;
        end else if (sclk_rise) begin
          cmd_n     = shifted[CMD_W-2:0];
          bit_cnt_n = bit_cnt + 5'd1;
          if (bit_cnt == LAST_CMD) begin
            addr_n    = shifted[ADDR_W-1:0];
            bit_cnt_n = '0;
            all_n     = 1'b0;
            pend_n    = 1'b0;
            data_n    = 16'hFFFF;
            case (shifted[CMD_W-1 -: 2])
              OP_READ: begin
                state_n = READ;
                sdo_n   = 1'b0;
              end
              OP_WRITE: state_n = WDATA;
              OP_ERASE: begin
                state_n = WAITCS;
                pend_n  = wen;
              end
              default: begin
                case (shifted[ADDR_W-1 -: 2])
                  EXT_EWEN: begin
                    wen_n   = 1'b1;
                    state_n = WAITCS;
                  end
                  EXT_EWDS: begin
                    wen_n   = 1'b0;
                    state_n = WAITCS;
                  end
                  EXT_ERAL: begin
                    all_n   = 1'b1;
                    pend_n  = wen;
                    state_n = WAITCS;
                  end
                  default: begin
                    all_n   = 1'b1;
                    state_n = WDATA;
                  end
                endcase
              end
            endcase
          end
        end
      end
      READ: begin
        if (!scs) begin
          state_n = IDLE;
          sdo_n   = 1'b1;
        end else if (sclk_rise) begin
          sdo_n = ram_a_q[4'd15 - bit_cnt[3:0]];
          if (bit_cnt == 5'd15) begin
            bit_cnt_n = '0;
            addr_n    = addr + ADDR_W'(1);
          end else begin
            bit_cnt_n = bit_cnt + 5'd1;
          end
        end
      end
      WDATA: begin
        if (!scs) begin
          state_n = IDLE;
        end else if (sclk_rise) begin
          data_n    = {data[14:0], sdi};
          bit_cnt_n = bit_cnt + 5'd1;
          if (bit_cnt == 5'd15) begin
            state_n = WAITCS;
            pend_n  = wen;
          end
        end
      end
      WAITCS: begin
        sdo_n = 1'b1;
        if (!scs) begin
          if (pending) begin
            state_n = BUSY;
            busy_n  = '0;
            sdo_n   = 1'b0;
          end else begin
            state_n = IDLE;
          end
        end
      end
      BUSY: begin
        sdo_n  = 1'b0;
        busy_n = busy_cnt + BW'(1);
        if (busy_cnt == LAST_BUSY) begin
          state_n = IDLE;
          pend_n  = 1'b0;
          sdo_n   = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Single-word commits land on the first busy cycle; bulk commits sweep one word per cycle
  always_comb begin
    we_a   = 1'b0;
    addr_a = addr;
    if (state == BUSY) begin
      if (all_op) begin
        we_a   = (busy_cnt < DEPTH_C);
        addr_a = busy_cnt[ADDR_W-1:0];
      end else begin
        we_a = (busy_cnt == '0);
      end
    end
  end

  always_comb begin
    host_dirty_n = dirty;
    if (we_a)
      host_dirty_n = 1'b1;
    else if (HOST_DIRTY_CLR)
      host_dirty_n = 1'b0;
  end

  garegga_eeprom_ram #(.ADDR_W(ADDR_W)) u_ram (
    .clk    (CLK),
    .addr_a (addr_a),
    .din_a  (data),
    .we_a   (we_a),
    .dout_a (ram_a_q),
    .addr_b (HOST_ADDR),
    .din_b  (HOST_DIN),
    .we_b   (HOST_WE),
    .dout_b (ram_b_q)
  );

  assign EEPROM_SDO = sdo;
  assign HOST_DOUT  = host_dout;
  assign DIRTY      = dirty;

endmodule

// File: tb/tb_garegga_eeprom.sv
// tb/tb_garegga_eeprom.sv - self-checking bench for garegga_eeprom against a word-level model
module tb_garegga_eeprom;

  localparam int AW   = 6;
  localparam int BUSY = 4800;

  localparam int K_HWR   = 0;
  localparam int K_SRD   = 1;
  localparam int K_SER   = 2;
  localparam int K_HRD   = 3;
  localparam int K_DIRTY = 4;

  typedef struct {
    int            kind;
    logic [1:0]    op;
    logic [AW-1:0] addr;
    logic [15:0]   data;
    int            exp;
  } vec_t;

  logic          CLK = 1'b0;
  logic          RESET_N = 1'b0;
  logic          SCS = 1'b0;
  logic          SCLK = 1'b0;
  logic          SDI = 1'b0;
  logic          SDO;
  logic [AW-1:0] HOST_ADDR = '0;
  logic [15:0]   HOST_DIN = '0;
  logic          HOST_WE = 1'b0;
  logic [15:0]   HOST_DOUT;
  logic          DIRTY;
  logic          HOST_DIRTY_CLR = 1'b0;

  int total = 0;
  int bad = 0;

  logic [15:0] mem_m [64];
  logic        wen_m = 1'b0;
  logic        dirty_m = 1'b0;
  logic [15:0] rd_buf [2];

  garegga_eeprom #(.ADDR_W(AW), .BUSY_CYCLES(BUSY)) dut (
    .CLK            (CLK),
    .RESET_N        (RESET_N),
    .EEPROM_SCS     (SCS),
    .EEPROM_SCLK    (SCLK),
    .EEPROM_SDI     (SDI),
    .EEPROM_SDO     (SDO),
    .HOST_ADDR      (HOST_ADDR),
    .HOST_DIN       (HOST_DIN),
    .HOST_WE        (HOST_WE),
    .HOST_DOUT      (HOST_DOUT),
    .DIRTY          (DIRTY),
    .HOST_DIRTY_CLR (HOST_DIRTY_CLR)
  );

  always #5 CLK = ~CLK;

  initial begin
    #(10 * 150000);
    $display("FAIL timeout: bench did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic sbit(input logic b, output logic o);
    SDI = b;
    tick(4);
    SCLK = 1'b1;
    tick(4);
    o = SDO;
    SCLK = 1'b0;
  endtask

  task automatic sbits(input logic [31:0] v, input int n, output logic o);
    o = 1'b1;
    for (int i = n - 1; i >= 0; i--) sbit(v[i], o);
  endtask

  task automatic host_write(input logic [AW-1:0] a, input logic [15:0] d);
    HOST_ADDR = a;
    HOST_DIN  = d;
    HOST_WE   = 1'b1;
    tick(1);
    HOST_WE   = 1'b0;
    mem_m[a]  = d;
  endtask

  task automatic host_read(input logic [AW-1:0] a, output logic [15:0] d);
    HOST_ADDR = a;
    tick(2);
    d = HOST_DOUT;
  endtask

  task automatic serial_read(input logic [AW-1:0] a, input int n, output logic dummy);
    logic o;
    SCS = 1'b1;
    tick(4);
    sbit(1'b0, o);
    sbits({23'b0, 1'b1, 2'b10, a}, 3 + AW, dummy);
    for (int w = 0; w < n; w++)
      for (int b = 15; b >= 0; b--) begin
        sbit(1'b0, o);
        rd_buf[w][b] = o;
      end
    SCS = 1'b0;
    tick(6);
  endtask

  task automatic send_frame(input logic [1:0] op, input logic [AW-1:0] a, input logic [15:0] d);
    logic o;
    SCS = 1'b1;
    tick(4);
    sbits({23'b0, 1'b1, op, a}, 3 + AW, o);
    if (op == 2'b01 || (op == 2'b00 && a[AW-1:AW-2] == 2'b01))
      sbits({16'b0, d}, 16, o);
  endtask

  task automatic drop_cs(output int lowc);
    lowc = 0;
    SCS = 1'b0;
    for (int t = 0; t < 6000; t++) begin
      @(negedge CLK);
      if (SDO === 1'b0) lowc++;
      else if (lowc > 0 || t > 20) break;
    end
  endtask

  task automatic serial_cmd(input logic [1:0] op, input logic [AW-1:0] a, input logic [15:0] d,
                            output int lowc);
    send_frame(op, a, d);
    drop_cs(lowc);
  endtask

  // Word-level model: what a 93C46 does to its contents for one complete frame
  task automatic model_serial(input logic [1:0] op, input logic [AW-1:0] a, input logic [15:0] d,
                              output int busy_exp);
    busy_exp = 0;
    if (op == 2'b00 && a[AW-1:AW-2] == 2'b11) wen_m = 1'b1;
    else if (op == 2'b00 && a[AW-1:AW-2] == 2'b00) wen_m = 1'b0;
    else if (op != 2'b10 && wen_m) begin
      busy_exp = BUSY;
      dirty_m  = 1'b1;
      if (op == 2'b01) mem_m[a] = d;
      else if (op == 2'b11) mem_m[a] = 16'hFFFF;
      else
        for (int i = 0; i < 64; i++) mem_m[i] = (a[AW-1:AW-2] == 2'b10) ? 16'hFFFF : d;
    end
  endtask

  initial begin
    vec_t          vecs [10];
    logic [15:0]   w;
    logic [AW-1:0] a;
    logic [1:0]    op;
    logic          d;
    int            lowc;
    int            be;
    int            sel;
    bit            ok;

    vecs[0] = '{K_HWR,   2'b00, 6'd5,       16'hA55A, 0};
    vecs[1] = '{K_SRD,   2'b10, 6'd5,       16'h0000, 'hA55A};
    vecs[2] = '{K_SER,   2'b00, 6'b110000,  16'h0000, 0};
    vecs[3] = '{K_SER,   2'b01, 6'd3,       16'h1234, BUSY};
    vecs[4] = '{K_HRD,   2'b00, 6'd3,       16'h0000, 'h1234};
    vecs[5] = '{K_DIRTY, 2'b00, 6'd0,       16'h0000, 1};
    vecs[6] = '{K_SER,   2'b00, 6'b000000,  16'h0000, 0};
    vecs[7] = '{K_SER,   2'b01, 6'd3,       16'h0000, 0};
    vecs[8] = '{K_HRD,   2'b00, 6'd3,       16'h0000, 'h1234};
    vecs[9] = '{K_DIRTY, 2'b00, 6'd0,       16'h0000, 1};

    tick(3);
    check("reset_sdo", 32'(SDO), 32'(1));
    check("reset_dirty", 32'(DIRTY), 32'(0));
    check("reset_host_dout", 32'(HOST_DOUT), 32'(0));
    RESET_N = 1'b1;
    tick(3);

    for (int i = 0; i < 64; i++) host_write(6'(i), 16'($urandom));

    for (int i = 0; i < 10; i++) begin
      case (vecs[i].kind)
        K_HWR: host_write(vecs[i].addr, vecs[i].data);
        K_SRD: begin
          serial_read(vecs[i].addr, 1, d);
          check($sformatf("vec%0d_dummy", i), 32'(d), 32'(0));
          check($sformatf("vec%0d_read", i), 32'(rd_buf[0]), 32'(vecs[i].exp));
        end
        K_SER: begin
          serial_cmd(vecs[i].op, vecs[i].addr, vecs[i].data, lowc);
          model_serial(vecs[i].op, vecs[i].addr, vecs[i].data, be);
          check($sformatf("vec%0d_busy", i), 32'(lowc), 32'(vecs[i].exp));
        end
        K_HRD: begin
          host_read(vecs[i].addr, w);
          check($sformatf("vec%0d_host", i), 32'(w), 32'(vecs[i].exp));
        end
        default: check($sformatf("vec%0d_dirty", i), 32'(DIRTY), 32'(vecs[i].exp));
      endcase
    end

    HOST_DIRTY_CLR = 1'b1;
    tick(1);
    HOST_DIRTY_CLR = 1'b0;
    tick(1);
    dirty_m = 1'b0;
    check("dirty_clear", 32'(DIRTY), 32'(dirty_m));

    // Host load and clear on the very cycle the serial WRITE commits
    serial_cmd(2'b00, 6'b110000, 16'h0, lowc);
    model_serial(2'b00, 6'b110000, 16'h0, be);
    send_frame(2'b01, 6'd9, 16'hBEEF);
    SCS = 1'b0;
    tick(3);
    HOST_ADDR = 6'd9;
    HOST_DIN = 16'h1111;
    HOST_WE = 1'b1;
    HOST_DIRTY_CLR = 1'b1;
    tick(1);
    HOST_WE = 1'b0;
    HOST_DIRTY_CLR = 1'b0;
    mem_m[9] = 16'hBEEF;
    dirty_m = 1'b1;
    ok = 1'b0;
    for (int t = 0; t < 6000; t++) begin
      @(negedge CLK);
      if (SDO === 1'b1 && t > 10) begin
        ok = 1'b1;
        break;
      end
    end
    check("collide_ready", 32'(ok), 32'(1));
    host_read(6'd9, w);
    check("collide_serial_wins", 32'(w), 32'(mem_m[9]));
    check("collide_dirty_set", 32'(DIRTY), 32'(dirty_m));

    serial_cmd(2'b00, 6'b100000, 16'h0, lowc);
    model_serial(2'b00, 6'b100000, 16'h0, be);
    check("eral_busy", 32'(lowc), 32'(be));
    for (int i = 0; i < 64; i++) begin
      host_read(6'(i), w);
      check($sformatf("eral_word%0d", i), 32'(w), 32'(16'hFFFF));
    end

    host_write(6'd63, 16'($urandom));
    host_write(6'd0, 16'($urandom));
    serial_read(6'd63, 2, d);
    check("wrap_dummy", 32'(d), 32'(0));
    check("wrap_word63", 32'(rd_buf[0]), 32'(mem_m[63]));
    check("wrap_word0", 32'(rd_buf[1]), 32'(mem_m[0]));

    for (int k = 0; k < 20; k++) begin
      a = 6'($urandom_range(0, 63));
      sel = $urandom_range(0, 2);
      if (sel == 0) host_write(a, 16'($urandom));
      else if (sel == 1) begin
        serial_read(a, 1, d);
        check($sformatf("rnd%0d_sread_dummy", k), 32'(d), 32'(0));
        check($sformatf("rnd%0d_sread_a%0d", k, a), 32'(rd_buf[0]), 32'(mem_m[a]));
      end else begin
        host_read(a, w);
        check($sformatf("rnd%0d_hread_a%0d", k, a), 32'(w), 32'(mem_m[a]));
      end
    end

    for (int k = 0; k < 3; k++) begin
      a = 6'($urandom_range(0, 63));
      w = 16'($urandom);
      sel = $urandom_range(0, 2);
      op = (sel == 0) ? 2'b01 : (sel == 1) ? 2'b11 : 2'b00;
      if (sel == 2) a = {2'b01, a[AW-3:0]};
      serial_cmd(2'b00, 6'b110000, 16'h0, lowc);
      model_serial(2'b00, 6'b110000, 16'h0, be);
      check($sformatf("rcmt%0d_ewen_busy", k), 32'(lowc), 32'(be));
      serial_cmd(op, a, w, lowc);
      model_serial(op, a, w, be);
      check($sformatf("rcmt%0d_op%0d_busy", k, op), 32'(lowc), 32'(be));
      for (int j = 0; j < 4; j++) begin
        a = (j == 0) ? a : 6'($urandom_range(0, 63));
        host_read(a, w);
        check($sformatf("rcmt%0d_word_a%0d", k, a), 32'(w), 32'(mem_m[a]));
      end
      check($sformatf("rcmt%0d_dirty", k), 32'(DIRTY), 32'(dirty_m));
    end

    // WRITE cut off after 5 of 6 address bits, with write-enable still set
    SCS = 1'b1;
    tick(4);
    sbits({24'b0, 1'b1, 2'b01, 5'b00001}, 8, d);
    drop_cs(lowc);
    check("abort_no_busy", 32'(lowc), 32'(0));
    check("abort_sdo", 32'(SDO), 32'(1));
    host_read(6'd3, w);
    check("abort_mem", 32'(w), 32'(mem_m[3]));

    SCS = 1'b1;
    tick(4);
    sbits({23'b0, 1'b1, 2'b10, 6'd5}, 3 + AW, d);
    for (int b = 0; b < 5; b++) sbit(1'b0, d);
    RESET_N = 1'b0;
    #1;
    check("midread_rst_sdo", 32'(SDO), 32'(1));
    check("midread_rst_dirty", 32'(DIRTY), 32'(0));
    check("midread_rst_host_dout", 32'(HOST_DOUT), 32'(0));
    SCS = 1'b0;
    SCLK = 1'b0;
    tick(3);
    RESET_N = 1'b1;
    tick(3);
    wen_m = 1'b0;
    dirty_m = 1'b0;
    serial_read(6'd5, 1, d);
    check("post_rst_dummy", 32'(d), 32'(0));
    check("post_rst_read5", 32'(rd_buf[0]), 32'(mem_m[5]));
    serial_cmd(2'b01, 6'd5, 16'h0F0F, lowc);
    model_serial(2'b01, 6'd5, 16'h0F0F, be);
    check("post_rst_wen_clear", 32'(lowc), 32'(be));
    host_read(6'd5, w);
    check("post_rst_mem5", 32'(w), 32'(mem_m[5]));
    check("post_rst_dirty", 32'(DIRTY), 32'(dirty_m));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/garegga_eeprom.md
GAREGGA_EEPROM -- requirements
Module: garegga_eeprom

Interface
REQ-001 SHALL have parameter ADDR_W, default 6, word-address width (64 words).
REQ-002 SHALL have parameter BUSY_CYCLES, default 4800, CLK cycles of self-timed program/erase busy (100 us at 48 MHz).
REQ-003 SHALL have port CLK, input, 1, 48 MHz system clock, the single clock of the block.
REQ-004 SHALL have port RESET_N, input, 1, reset, asynchronous and active-low.
REQ-005 SHALL have port EEPROM_SCS, input, 1, chip select from the CPU I/O latch, active-high.
REQ-006 SHALL have port EEPROM_SCLK, input, 1, serial clock from the CPU, asynchronous to CLK.
REQ-007 SHALL have port EEPROM_SDI, input, 1, serial data from the CPU.
REQ-008 SHALL have port EEPROM_SDO, output, 1, serial data and ready/busy status to the CPU.
REQ-009 SHALL have port HOST_ADDR, input, ADDR_W, NVRAM load/save word address.
REQ-010 SHALL have port HOST_DIN, input, 16, NVRAM load data.
REQ-011 SHALL have port HOST_WE, input, 1, NVRAM load write strobe, one word per CLK cycle.
REQ-012 SHALL have port HOST_DOUT, output, 16, word at HOST_ADDR, 1-cycle read latency.
REQ-013 SHALL have port DIRTY, output, 1, set by any serial commit, cleared by HOST_DIRTY_CLR.
REQ-014 SHALL have port HOST_DIRTY_CLR, input, 1, single-cycle clear of DIRTY.

Function
REQ-015 SHALL emulate a 93C46 in x16 mode: start bit 1, 2-bit opcode, ADDR_W address bits, MSB first.
REQ-016 SHALL pass SCS, SCLK and SDI through 2-FF synchronizers, with SDI sampled on the synchronized SCLK rising edge.
REQ-017 SHALL use states IDLE, CMD, READ, WDATA, BUSY, WAITCS.
REQ-018 SHALL, in IDLE with SCS high, ignore 0 bits and enter CMD on the first 1 bit.
REQ-019 SHALL, in CMD, shift 2+ADDR_W bits and then decode: 10 READ, 01 WRITE, 11 ERASE, 00 with addr[5:4] 11 EWEN / 00 EWDS / 10 ERAL / 01 WRAL.
REQ-020 SHALL, for READ, drive SDO=0 (dummy bit) after the last address bit, then 16 data bits MSB first, each updated on SCLK rising edge.
REQ-021 SHALL, in READ, continue with the next address after bit 0 while SCS stays high, wrapping 63->0.
REQ-022 SHALL shift 16 data bits in WDATA for WRITE and WRAL.
REQ-023 SHALL commit WRITE/ERASE/ERAL/WRAL on the SCS falling edge after a complete frame, only if write-enable is set; otherwise go to WAITCS with no change.
REQ-024 SHALL make ERASE write 16'hFFFF; ERAL and WRAL SHALL iterate all words, one per CLK cycle, inside BUSY.
REQ-025 SHALL hold BUSY for BUSY_CYCLES; while SCS is high, SDO SHALL read 0 when busy and 1 when ready; SDO SHALL be 1 at all other idle times.
REQ-026 SHALL make EWEN/EWDS set/clear write-enable immediately, then go to WAITCS.
REQ-027 SHALL abort any incomplete frame on SCS low and return to IDLE with no memory change.
REQ-028 SHALL ignore SCS changes during BUSY; the commit always completes.
REQ-029 SHALL apply a HOST_WE write in the same cycle; on a simultaneous serial commit to the same address the serial data wins.
REQ-030 SHALL set DIRTY on every committed serial write, with set taking priority over a simultaneous HOST_DIRTY_CLR.

Reset
REQ-031 SHALL make reset force state IDLE, SDO=1, write-enable=0, DIRTY=0, HOST_DOUT=0, and clear the shift registers and synchronizers.
REQ-032 SHALL NOT let reset alter memory contents; reset during BUSY abandons the remaining ERAL/WRAL words.

Structure
REQ-033 SHALL put the opcode constants and the state enum in shared package garegga_pkg.
REQ-034 SHALL implement storage as one sub-module, garegga_eeprom_ram: dual-port 64x16, port A serial side, port B host side, no reset.

Verification
REQ-035 SHALL cover: HOST_WE load addr 5 = 16'hA55A, serial READ addr 5 -> SDO yields dummy 0 then 1010010101011010.
REQ-036 SHALL cover: EWEN, WRITE addr 3 = 16'h1234, SCS low -> SDO 0 for 4800 cycles then 1; HOST_DOUT at addr 3 = 16'h1234; DIRTY=1.
REQ-037 SHALL cover: EWDS then WRITE addr 3 = 16'h0000 -> addr 3 remains 16'h1234, DIRTY unchanged, no busy period.
REQ-038 SHALL cover: EWEN, ERAL -> all 64 words read 16'hFFFF via host port.
REQ-039 SHALL cover: READ at addr 63 continuing 32 clocks -> words 63 then 0 output.
REQ-040 SHALL cover: SCS dropped after 5 address bits of WRITE, and RESET_N asserted mid-READ -> memory unchanged, SDO=1, state IDLE.
